// File: rtl/prefix_result_buffer.sv
// prefix_result_buffer
//   Tracks operands issued to a fixed-latency prefix adder and captures each adder result
//   LAT edges after its issue. The result goes into a first-word-fall-through FIFO
//   together with {Z,N,C,V} flags. Issue is throttled so that every in-flight result
//   already has a FIFO slot reserved, so the FIFO can never overflow.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready : operand issue handshake (in_ready = a result slot is reserved)
//   x_msb, y_msb        : sign bits of the issued operands, carried alongside the issue tag
//   sum, cout           : adder outputs, sampled when the matching tag leaves the line
//   out_valid/out_ready : FIFO head handshake
//   out_sum, out_flags  : head entry, or zero when the FIFO is empty
//   out_count           : FIFO occupancy
module prefix_result_buffer #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     x_msb,
  input  logic                     y_msb,
  input  logic [31:0]              sum,
  input  logic                     cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_sum,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(LAT + 1);

  // Tag shift line: stage 0 holds an issue accepted on the previous edge.
  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0] tag_x_q, tag_x_d;
  logic [LAT-1:0] tag_y_q, tag_y_d;

  logic [IW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;

  logic [31:0]    mem_sum_q   [DEPTH];
  logic [3:0]     mem_flags_q [DEPTH];

  logic           accept;
  logic           push;
  logic           pop;
  logic           push_x;
  logic           push_y;
  logic [3:0]     push_flags;

  always_comb begin
    // Slots already promised to in-flight results count as occupied.
    in_ready = (32'(count_q) + 32'(inflight_q)) < DEPTH;
    accept   = in_valid && in_ready;

    push     = tag_v_q[LAT-1];
    push_x   = tag_x_q[LAT-1];
    push_y   = tag_y_q[LAT-1];
    pop      = (count_q != '0) && out_ready;

    // {Z, N, C, V}; V is signed overflow of x + y seen through the operand sign bits.
    push_flags = {(sum == 32'd0), sum[31], cout, (push_x == push_y) && (sum[31] != push_x)};

    tag_v_d    = '0;
    tag_x_d    = '0;
    tag_y_d    = '0;
    tag_v_d[0] = accept;
    tag_x_d[0] = x_msb;
    tag_y_d[0] = y_msb;
    for (int i = 1; i < int'(LAT); i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_x_d[i] = tag_x_q[i-1];
      tag_y_d[i] = tag_y_q[i-1];
    end

    inflight_d = inflight_q;
    unique case ({accept, push})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Pointers wrap naturally because DEPTH is a power of two.
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;

    out_valid = (count_q != '0);
    out_count = count_q;
    out_sum   = out_valid ? mem_sum_q[rptr_q]   : 32'd0;
    out_flags = out_valid ? mem_flags_q[rptr_q] : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q    <= '0;
      tag_x_q    <= '0;
      tag_y_q    <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      tag_v_q    <= tag_v_d;
      tag_x_q    <= tag_x_d;
      tag_y_q    <= tag_y_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Storage needs no reset: reads are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sum_q[wptr_q]   <= sum;
      mem_flags_q[wptr_q] <= push_flags;
    end
  end

endmodule

// File: tb/tb_prefix_result_buffer.sv
// Self-checking bench for prefix_result_buffer (LAT=4, DEPTH=4). The bench plays the adder:
// LAT edges after an issue it drives the true x+y+c result, otherwise random junk.
// A queue-based model predicts in_ready and the FIFO contents.
module tb_prefix_result_buffer;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        x_msb = 1'b0;
  logic        y_msb = 1'b0;
  logic [31:0] sum = 32'd0;
  logic        cout = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic [3:0]  out_flags;
  logic [2:0]  out_count;

  prefix_result_buffer #(
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_msb     (x_msb),
    .y_msb     (y_msb),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        c;
    int          due;
  } op_t;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic [3:0]  f;
  } res_t;

  op_t  pend[$];
  res_t fifo[$];
  int   edge_n    = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   acc_count = 0;

  function automatic res_t ref_result(input op_t o);
    res_t        r;
    logic [32:0] full;
    full = {1'b0, o.x} + {1'b0, o.y} + {32'd0, o.c};
    r.s  = full[31:0];
    r.co = full[32];
    r.f  = {(r.s == 32'd0), r.s[31], r.co, (o.x[31] == o.y[31]) && (r.s[31] != o.x[31])};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    if (fifo.size() > 0) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_sum", out_sum, fifo[0].s);
      chk("out_flags", 32'(out_flags), 32'(fifo[0].f));
    end else begin
      chk("out_valid", 32'(out_valid), 32'd0);
      chk("out_sum_zero", out_sum, 32'd0);
      chk("out_flags_zero", 32'(out_flags), 32'd0);
    end
    chk("out_count", 32'(out_count), 32'(fifo.size()));
    chk("count_le_depth", 32'(out_count <= DEPTH), 32'd1);
  endtask

  // One clock: drive at the falling edge, model the rising edge, check 1 time unit later.
  task automatic cycle(input logic iv, input logic ory,
                       input logic [31:0] x, input logic [31:0] y, input logic c);
    logic exp_ready;
    logic m_acc;
    logic m_pop;
    logic m_push;
    res_t r;
    op_t  o;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ory;
    x_msb     = x[31];
    y_msb     = y[31];
    m_push    = (pend.size() > 0) && (pend[0].due == edge_n);
    if (m_push) begin
      r    = ref_result(pend[0]);
      sum  = r.s;
      cout = r.co;
    end else begin
      sum  = $urandom;
      cout = 1'($urandom);
    end
    exp_ready = (fifo.size() + pend.size()) < DEPTH;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    if (iv && in_ready) acc_count++;
    m_acc = iv && exp_ready;
    m_pop = (fifo.size() > 0) && ory;
    @(posedge clk);
    if (m_pop) void'(fifo.pop_front());
    if (m_push) fifo.push_back(ref_result(pend.pop_front()));
    if (m_acc) begin
      o.x   = x;
      o.y   = y;
      o.c   = c;
      o.due = edge_n + LAT;
      pend.push_back(o);
    end
    edge_n++;
    #1;
    check_outputs();
  endtask

  task automatic rand_cycle(input logic iv, input logic ory);
    cycle(iv, ory, $urandom, $urandom, 1'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    pend.delete();
    fifo.delete();
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_count", 32'(out_count), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      edge_n++;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      check_outputs();
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    check_outputs();
  endtask

  initial begin
    // Reset state
    do_reset();

    // Basic result and latency: nothing visible after 3 edges, visible after the 4th
    cycle(1'b1, 1'b0, 32'd1, 32'd2, 1'b1);
    for (int i = 0; i < 3; i++) rand_cycle(1'b0, 1'b0);
    chk("latency_not_early", 32'(out_valid), 32'd0);
    rand_cycle(1'b0, 1'b0);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_sum", out_sum, 32'd4);
    chk("basic_flags", 32'(out_flags), 32'b0000);
    rand_cycle(1'b0, 1'b1);

    // Signed overflow into negative
    cycle(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    for (int i = 0; i < 4; i++) rand_cycle(1'b0, 1'b0);
    chk("ovf_sum", out_sum, 32'h8000_0000);
    chk("ovf_flags", 32'(out_flags), 32'b0101);
    rand_cycle(1'b0, 1'b1);

    // Zero with carry out
    cycle(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    for (int i = 0; i < 4; i++) rand_cycle(1'b0, 1'b0);
    chk("zc_sum", out_sum, 32'd0);
    chk("zc_flags", 32'(out_flags), 32'b1010);
    rand_cycle(1'b0, 1'b1);

    // Backpressure: exactly DEPTH accepts, then one pop frees exactly one slot
    do_reset();
    acc_count = 0;
    for (int i = 0; i < 10; i++) rand_cycle(1'b1, 1'b0);
    chk("fill_accepts", 32'(acc_count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(out_count), 32'd4);
    acc_count = 0;
    rand_cycle(1'b1, 1'b1);
    chk("pop_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) rand_cycle(1'b1, 1'b0);
    chk("refill_accepts", 32'(acc_count), 32'd1);
    chk("refill_count", 32'(out_count), 32'd4);

    // Full FIFO drained while issuing continuously; model checks order and timing
    for (int i = 0; i < 40; i++) rand_cycle(1'b1, 1'b1);

    // Reset discards in-flight results
    do_reset();
    rand_cycle(1'b1, 1'b0);
    rand_cycle(1'b1, 1'b0);
    rand_cycle(1'b0, 1'b0);
    rand_cycle(1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rand_cycle(1'b0, 1'b0);
      chk("discard_valid", 32'(out_valid), 32'd0);
      chk("discard_ready", 32'(in_ready), 32'd1);
    end

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(59) == 0) do_reset();
      else rand_cycle(1'($urandom_range(3) != 0), 1'($urandom_range(2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
